// File: rtl/player_motion_if.sv
// Key/position bundle between the keyboard front end, the motion engine and the colour mapper.
interface player_motion_if #(
    parameter int KEY_CH   = 2,
    parameter int SCROLL_W = 6
);
    logic [8*KEY_CH-1:0] keycodes;
    logic [9:0]          PlayerX;
    logic [9:0]          PlayerY;
    logic [9:0]          PlayerSX;
    logic [9:0]          PlayerSY;
    logic [SCROLL_W-1:0] scroll;
    logic [1:0]          state;
    logic                jump_start;

    modport master (
        output keycodes,
        input  PlayerX, PlayerY, PlayerSX, PlayerSY, scroll, state, jump_start
    );

    modport slave (
        input  keycodes,
        output PlayerX, PlayerY, PlayerSX, PlayerSY, scroll, state, jump_start
    );
endinterface

// File: rtl/player_motion.sv
// Per-frame player sprite motion: walk/scroll, edge-triggered jump FSM, saturating bounds.
// Optional variable jump height when PLAYER_MOTION_VARJUMP_EN is defined.
module player_motion #(
    parameter int         KEY_CH     = 2,
    parameter int         X_START    = 80,
    parameter int         GROUND_Y   = 378,
    parameter int         JUMP_H     = 78,
    parameter int         RISE_STEP  = 3,
    parameter int         FALL_STEP  = 3,
    parameter int         WALK_STEP  = 1,
    parameter int         SIZE_X     = 10,
    parameter int         SIZE_Y     = 20,
    parameter int         X_MAX      = 699,
    parameter int         SCROLL_X   = 320,
    parameter int         SCROLL_MAX = 60,
    parameter int         SCROLL_W   = 6,
    parameter logic [7:0] KEY_RIGHT  = 8'h07,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_JUMP   = 8'h1A
) (
    input  logic           frame_clk,
    input  logic           Reset_n,
    player_motion_if.slave pm
);
    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } state_e;

    localparam logic [9:0]  X_START_C  = 10'(X_START);
    localparam logic [9:0]  GROUND_C   = 10'(GROUND_Y);
    localparam logic [10:0] GROUND_W   = 11'(GROUND_Y);
    localparam logic [9:0]  JUMP_H_C   = 10'(JUMP_H);
    localparam logic [9:0]  RISE_C     = 10'(RISE_STEP);
    localparam logic [10:0] RISE_W     = 11'(RISE_STEP);
    localparam logic [9:0]  FALL_C     = 10'(FALL_STEP);
    localparam logic [10:0] FALL_W     = 11'(FALL_STEP);
    localparam logic [10:0] WALK_W     = 11'(WALK_STEP);
    localparam logic [9:0]  X_HI_C     = 10'(X_MAX - SIZE_X);
    localparam logic [10:0] X_HI_W     = 11'(X_MAX - SIZE_X);
    localparam logic [9:0]  X_LO_C     = 10'(SIZE_X);
    localparam logic [10:0] X_LO_W     = 11'(SIZE_X + WALK_STEP);
    localparam logic [9:0]  SCROLL_X_C = 10'(SCROLL_X);
    localparam logic [SCROLL_W-1:0] SCROLL_MAX_C = SCROLL_W'(SCROLL_MAX);
    localparam logic [SCROLL_W-1:0] SCROLL_ONE   = SCROLL_W'(1);

    logic [KEY_CH-1:0] right_hit, left_hit, jump_hit;
    logic              right, left, jump;

    generate
        for (genvar gi = 0; gi < KEY_CH; gi++) begin : g_key
            assign right_hit[gi] = (pm.keycodes[8*gi +: 8] == KEY_RIGHT);
            assign left_hit[gi]  = (pm.keycodes[8*gi +: 8] == KEY_LEFT);
            assign jump_hit[gi]  = (pm.keycodes[8*gi +: 8] == KEY_JUMP);
        end
    endgenerate

    assign right = |right_hit;
    assign left  = |left_hit;
    assign jump  = |jump_hit;

    state_e              state_q, state_d;
    logic [9:0]          x_q, x_d, y_q, y_d, apex_q, apex_d;
    logic [SCROLL_W-1:0] scroll_q, scroll_d;
    logic                jump_prev_q, jump_start_q, jump_start_d;

    // Widened sums let bound checks see the carry before truncation to 10 bits.
    logic [10:0] x_inc, x_lo_chk, y_rise_chk, apex_rise, y_fall_chk;
    assign x_inc      = {1'b0, x_q} + WALK_W;
    assign x_lo_chk   = {1'b0, x_q};
    assign y_rise_chk = {1'b0, y_q};
    assign apex_rise  = {1'b0, apex_q} + RISE_W;
    assign y_fall_chk = {1'b0, y_q} + FALL_W;

    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        apex_d       = apex_q;
        jump_start_d = 1'b0;
        x_d          = x_q;
        scroll_d     = scroll_q;

        unique case (state_q)
            GROUNDED: begin
                if (jump && !jump_prev_q) begin
                    apex_d       = (y_q < JUMP_H_C) ? 10'd0 : (y_q - JUMP_H_C);
                    state_d      = RISING;
                    jump_start_d = 1'b1;
                end
            end
            RISING: begin
`ifdef PLAYER_MOTION_VARJUMP_EN
                if (!jump) begin
                    state_d = FALLING;
                end else
`endif
                if (y_rise_chk <= apex_rise) begin
                    y_d     = apex_q;
                    state_d = FALLING;
                end else begin
                    y_d = y_q - RISE_C;
                end
            end
            FALLING: begin
                if (y_fall_chk >= GROUND_W) begin
                    y_d     = GROUND_C;
                    state_d = GROUNDED;
                end else begin
                    y_d = y_q + FALL_C;
                end
            end
            default: state_d = GROUNDED;
        endcase

        if (right && !left) begin
            if (x_q >= SCROLL_X_C && scroll_q < SCROLL_MAX_C) begin
                scroll_d = scroll_q + SCROLL_ONE;
            end else begin
                x_d = (x_inc > X_HI_W) ? X_HI_C : x_inc[9:0];
            end
        end else if (left && !right) begin
            x_d = (x_lo_chk < X_LO_W) ? X_LO_C : (x_q - WALK_W[9:0]);
        end
    end

    // jump_prev resets high so a key held through reset cannot trigger a take-off.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q      <= GROUNDED;
            x_q          <= X_START_C;
            y_q          <= GROUND_C;
            apex_q       <= GROUND_C;
            scroll_q     <= '0;
            jump_prev_q  <= 1'b1;
            jump_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            apex_q       <= apex_d;
            scroll_q     <= scroll_d;
            jump_prev_q  <= jump;
            jump_start_q <= jump_start_d;
        end
    end

    assign pm.PlayerX    = x_q;
    assign pm.PlayerY    = y_q;
    assign pm.PlayerSX   = 10'(SIZE_X);
    assign pm.PlayerSY   = 10'(SIZE_Y);
    assign pm.scroll     = scroll_q;
    assign pm.state      = state_q;
    assign pm.jump_start = jump_start_q;
endmodule
